// File: rtl/mux_scan.sv
// mux_scan: registered channel selector with a direct (sel/load) mode and an
// auto-scan mode that walks every channel in order, behind a valid/ready slot.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_bus     CHANNELS packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel        channel select used in direct mode
//   mode       0 = direct, 1 = scan
//   load       capture request in direct mode
//   out_ready  consumer accepts f/ch this cycle
//   f          registered selected data
//   ch         channel index that produced f
//   out_valid  f/ch hold an unconsumed result
//   sel_err    last direct capture used sel >= CHANNELS
//   scan_done  one-cycle pulse with the capture of channel CHANNELS-1
module mux_scan #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      load,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          f,
  output logic [SEL_W-1:0]          ch,
  output logic                      out_valid,
  output logic                      sel_err,
  output logic                      scan_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] ptr_data;
  logic             sel_ok;
  logic             slot_free;

  // Channel muxes; out-of-range selects fall through to zero.
  always_comb begin
    sel_data = '0;
    ptr_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) sel_data = in_bus[k*WIDTH +: WIDTH];
      if (ptr == SEL_W'(k)) ptr_data = in_bus[k*WIDTH +: WIDTH];
    end
  end

  assign sel_ok    = 32'(sel) < CHANNELS;
  assign slot_free = !out_valid || out_ready;

  // Mode FSM plus output slot. Captures are decided by the current state, so
  // the first edge out of IDLE only picks the mode and never captures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      f         <= '0;
      ch        <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state     <= mode ? SCAN : DIRECT;
      scan_done <= 1'b0;
      // Consumption clears the slot; a capture below on the same edge wins.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        DIRECT: begin
          ptr <= '0;
          if (load && slot_free) begin
            f         <= sel_ok ? sel_data : '0;
            ch        <= sel;
            out_valid <= 1'b1;
            sel_err   <= !sel_ok;
          end
        end
        SCAN: begin
          if (slot_free) begin
            f         <= ptr_data;
            ch        <= ptr;
            out_valid <= 1'b1;
            sel_err   <= 1'b0;
            scan_done <= (ptr == LAST_CH);
            ptr       <= (ptr == LAST_CH) ? '0 : ptr + SEL_W'(1);
          end
        end
        default: begin
          ptr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: a reference model pushes expected results,
// a negedge monitor pops them whenever the DUT presents a fresh result.
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_bus;
  logic [23:0] in_bus6;
  logic [2:0]  sel;
  logic        mode;
  logic        load;
  logic        out_ready;

  logic [3:0]  f,  f6;
  logic [2:0]  ch, ch6;
  logic        out_valid, out_valid6;
  logic        sel_err, sel_err6;
  logic        scan_done, scan_done6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign in_bus6 = in_bus[23:0];

  mux_scan #(.WIDTH(4), .CHANNELS(8), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .mode(mode),
    .load(load), .out_ready(out_ready), .f(f), .ch(ch),
    .out_valid(out_valid), .sel_err(sel_err), .scan_done(scan_done)
  );

  mux_scan #(.WIDTH(4), .CHANNELS(6), .SEL_W(3)) dut6 (
    .clk(clk), .rst(rst), .in_bus(in_bus6), .sel(sel), .mode(mode),
    .load(load), .out_ready(out_ready), .f(f6), .ch(ch6),
    .out_valid(out_valid6), .sel_err(sel_err6), .scan_done(scan_done6)
  );

  typedef struct packed {
    logic [3:0] f;
    logic [2:0] ch;
    logic       err;
  } exp_t;

  // ---------------- reference model (8-channel DUT) ----------------
  exp_t q[$];
  int   m_mode;      // -1 = just reset, 0 = direct, 1 = scan (mode seen last edge)
  int   m_ptr;
  bit   m_valid;
  bit   m_done;
  bit   m_free;
  bit   m_cap;
  exp_t m_e;

  function automatic logic [3:0] chan(input logic [31:0] bus, input int k);
    return 4'(bus >> (4 * k));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  = -1;
      m_ptr   = 0;
      m_valid = 0;
      m_done  = 0;
      q.delete();
    end else begin
      m_free = !m_valid || out_ready;
      m_cap  = 0;
      m_done = 0;
      if (m_mode != 1) m_ptr = 0;
      if (m_mode == 0 && load && m_free) begin
        m_cap   = 1;
        m_e.ch  = sel;
        m_e.err = (int'(sel) >= 8);
        m_e.f   = m_e.err ? 4'd0 : chan(in_bus, int'(sel));
      end else if (m_mode == 1 && m_free) begin
        m_cap   = 1;
        m_e.ch  = 3'(m_ptr);
        m_e.err = 0;
        m_e.f   = chan(in_bus, m_ptr);
        m_done  = (m_ptr == 7);
        m_ptr   = (m_ptr + 1) % 8;
      end
      if (m_cap) begin
        q.push_back(m_e);
        m_valid = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
      m_mode = mode ? 1 : 0;
    end
  end

  // ---------------- monitor ----------------
  bit   fresh = 1;
  exp_t held;

  always @(negedge clk) begin
    if (rst) begin
      fresh = 1;
    end else begin
      n_tests++;
      if (out_valid !== m_valid) begin
        n_fail++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
      end
      n_tests++;
      if (scan_done !== m_done) begin
        n_fail++;
        $display("FAIL scan_done: got %b expected %b at %0t", scan_done, m_done, $time);
      end
      if (out_valid) begin
        if (fresh) begin
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: ch=%0d f=%0d with empty queue at %0t", ch, f, $time);
          end else begin
            held = q.pop_front();
          end
          fresh = 0;
        end
        n_tests++;
        if ({f, ch, sel_err} !== held) begin
          n_fail++;
          $display("FAIL result: got f=%0d ch=%0d err=%b expected f=%0d ch=%0d err=%b at %0t",
                   f, ch, sel_err, held.f, held.ch, held.err, $time);
        end
      end
      if (out_valid && out_ready) fresh = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 8; k++) in_bus[k*4 +: 4] = 4'(k + 1);
  endtask

  bit found;

  initial begin
    rst = 1; mode = 0; load = 0; sel = 0; out_ready = 1;
    set_ramp();
    #3;
    check("reset_f", 32'(f), 0);
    check("reset_ch", 32'(ch), 0);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_done", 32'(scan_done), 0);
    tick();
    rst = 0;
    tick();                                  // IDLE -> DIRECT, no capture
    check("no_capture_after_reset", 32'(out_valid), 0);

    // direct capture of channel 5
    sel = 5; load = 1; out_ready = 1;
    tick();
    check("direct_f", 32'(f), 6);
    check("direct_ch", 32'(ch), 5);
    load = 0;
    tick();

    // backpressure: hold f=6 while load sel=2 is requested
    sel = 5; load = 1; out_ready = 0;
    tick();
    sel = 2;
    repeat (3) begin
      tick();
      check("backpressure_hold", 32'(f), 6);
    end
    out_ready = 1;
    tick();
    check("after_release_f", 32'(f), 3);
    load = 0;
    tick();

    // bad select on the 6-channel instance, valid select on both
    sel = 7; load = 1; out_ready = 1;
    tick();
    check("bad_sel_f", 32'(f6), 0);
    check("bad_sel_ch", 32'(ch6), 7);
    check("bad_sel_err", 32'(sel_err6), 1);
    check("bad_sel_valid", 32'(out_valid6), 1);
    sel = 5;
    tick();
    check("good_sel6_f", 32'(f6), 6);
    check("good_sel6_err", 32'(sel_err6), 0);
    load = 0;
    tick();

    // scan wrap: 12 cycles with ready held
    mode = 1; load = 1; sel = 3;
    repeat (12) tick();

    // scan stall at ch=3 for 4 cycles
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (out_valid && ch == 3) found = 1;
    end
    check("stall_found_ch3", 32'(found), 1);
    out_ready = 0;
    repeat (4) begin
      tick();
      check("stall_hold_ch", 32'(ch), 3);
      check("stall_hold_f", 32'(f), 4);
    end
    out_ready = 1;
    tick();
    check("stall_release_ch", 32'(ch), 4);
    repeat (3) tick();

    // async reset mid-scan at ch=4
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (out_valid && ch == 4) found = 1;
    end
    check("reset_found_ch4", 32'(found), 1);
    #2 rst = 1;
    #1;
    check("async_rst_f", 32'(f), 0);
    check("async_rst_ch", 32'(ch), 0);
    check("async_rst_valid", 32'(out_valid), 0);
    tick();
    rst = 0;
    tick();                                  // IDLE -> SCAN
    tick();
    check("scan_restart_ch", 32'(ch), 0);
    check("scan_restart_valid", 32'(out_valid), 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_bus    = $urandom;
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      load      = 1'($urandom_range(0, 1));
      sel       = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 300) begin
        #2 rst = 1;
        tick();
        #1 rst = 0;
      end
      tick();
    end

    out_ready = 1; load = 0;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 The module SHALL provide parameter WIDTH, default 4, data width per channel in bits.
REQ-002 The module SHALL provide parameter CHANNELS, default 8, number of input channels (2..256).
REQ-003 The module SHALL provide parameter SEL_W, default 3, select/pointer width; CHANNELS <= 2**SEL_W.
REQ-004 The module SHALL provide port clk  input  1  single rising-edge clock for all state.
REQ-005 The module SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-006 The module SHALL provide port in_bus  input  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 The module SHALL provide port sel  input  SEL_W  channel select in direct mode.
REQ-008 The module SHALL provide port mode  input  1  0 = direct, 1 = scan.
REQ-009 The module SHALL provide port load  input  1  capture request in direct mode.
REQ-010 The module SHALL provide port out_ready  input  1  consumer accepts f this cycle.
REQ-011 The module SHALL provide port f  output  WIDTH  registered selected data.
REQ-012 The module SHALL provide port ch  output  SEL_W  channel index that produced f.
REQ-013 The module SHALL provide port out_valid  output  1  f/ch hold an unconsumed result.
REQ-014 The module SHALL provide port sel_err  output  1  registered flag: last direct capture used sel >= CHANNELS.
REQ-015 The module SHALL provide port scan_done  output  1  one-cycle pulse when the scan capture of channel CHANNELS-1 is accepted.

Function
REQ-016 The output slot SHALL be free in a cycle when out_valid = 0 or out_ready = 1.
REQ-017 The output slot SHALL be consumed on a rising edge with out_valid = 1 and out_ready = 1; with no new capture, out_valid SHALL then go to 0.
REQ-018 When out_valid = 1 and out_ready = 0, f, ch, out_valid and sel_err SHALL hold their values (no overwrite).
REQ-019 The state machine SHALL have states IDLE, DIRECT and SCAN; IDLE is entered on reset, DIRECT when mode = 0 and SCAN when mode = 1, each evaluated every cycle.
REQ-020 In DIRECT, when load = 1 and the slot is free, the module SHALL register f = channel sel, ch = sel, out_valid = 1, sel_err = 0, with one-cycle latency.
REQ-021 In DIRECT, when load = 1, the slot is free and sel >= CHANNELS, the module SHALL register f = 0, ch = sel, out_valid = 1, sel_err = 1.
REQ-022 In DIRECT, load = 1 with the slot not free SHALL be dropped: no queueing and no state change.
REQ-023 In SCAN, an internal pointer ptr SHALL select the channel; each cycle the slot is free, the module SHALL register f = channel ptr, ch = ptr, out_valid = 1, sel_err = 0, and advance ptr.
REQ-024 ptr SHALL wrap from CHANNELS-1 to 0; it SHALL never hold a value >= CHANNELS.
REQ-025 scan_done SHALL pulse high for exactly the cycle after the capture of channel CHANNELS-1; otherwise it SHALL be 0.
REQ-026 On entry to SCAN from any other state, ptr SHALL be 0 for the first scan capture.
REQ-027 In SCAN, load and sel SHALL be ignored.
REQ-028 When mode changes while out_valid = 1 and out_ready = 0, the held result SHALL persist until consumed.
REQ-029 When consumption and a new capture occur in the same edge, the new capture SHALL win and out_valid SHALL stay 1.
REQ-030 Only f, ch, out_valid, sel_err and scan_done SHALL be driven from registers; no combinational path SHALL run from in_bus to f.

Reset
REQ-031 While rst = 1, independent of clk, the module SHALL force f = 0, ch = 0, out_valid = 0, sel_err = 0, scan_done = 0, ptr = 0 and state = IDLE.
REQ-032 On the first rising edge after rst deasserts, the module SHALL leave IDLE according to mode; no capture SHALL occur on that edge.
REQ-033 Reset asserted mid-scan or while out_valid = 1 SHALL discard the pending result immediately.

Verification (WIDTH=4, CHANNELS=8, channel k = k+1 unless stated)
REQ-034 Direct capture: mode=0, sel=5, load=1, out_ready=1 -> next cycle f=6, ch=5, out_valid=1, sel_err=0.
REQ-035 Backpressure: out_valid=1, f=6, out_ready=0, load=1 with sel=2 for 3 cycles -> f stays 6; raise out_ready -> the next capture gives f=3.
REQ-036 Scan wrap: mode=1, out_ready=1 held for 10 cycles -> ch sequence 0..7,0,1; f sequence 1..8,1,2; scan_done high only after ch=7.
REQ-037 Scan stall: in scan, out_ready=0 at ch=3 for 4 cycles -> ch/f hold 3/4; on release -> ch=4, with no channel skipped.
REQ-038 Bad select: parameter CHANNELS=6, mode=0, sel=7, load=1 -> f=0, ch=7, sel_err=1.
REQ-039 Async reset: assert rst between clock edges during scan at ch=4 -> outputs go to zero before the next edge; after release with mode=1, the first capture is ch=0.
